// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline boundary register.
// Sits between fetch and decode. It holds up to two fetched instructions:
// a main entry that drives the decode-side outputs and a skid entry that
// catches the one instruction fetch may issue after decode stalls.
// A branch flush squashes everything in flight, presents a NOP bubble and
// adds the number of squashed valid instructions to a saturating counter.
//
// Handshake contract (both sides): a transfer happens on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge.
// A producer holding valid keeps its payload stable until the transfer.
// in_ready depends only on the occupancy state and do_branch, never on
// in_valid, so fetch may compute in_valid from in_ready without a loop.
module if_id_skid_reg #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    // fetch side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      instruction_in,
    input  logic [XLEN-1:0]  pc_plus_4_in,
    // flush request from execute
    input  logic             do_branch,
    // decode side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic [31:0]      instruction_out,
    output logic [XLEN-1:0]  pc_plus_4_out,
    // squashed-instruction statistics
    output logic [CNT_W-1:0] flush_count,
    // occupancy state for checkers: 0 = EMPTY, 1 = ONE, 2 = FULL
    output logic [1:0]       state_dbg
);

    // Occupancy states. The encoding equals the number of valid entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [XLEN-1:0] pc_plus_4;
    } entry_t;

    // The bubble is what decode sees whenever there is nothing real to show.
    localparam entry_t BUBBLE = '{pc: '0, insn: NOP_INSN, pc_plus_4: '0};

    logic [1:0] state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       out_valid_q;
    entry_t     in_entry;
    logic       accept;
    logic       consume;

    logic [1:0]     flush_addend;
    logic [CNT_W:0] flush_sum;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    assign in_entry = '{pc: pc_in, insn: instruction_in, pc_plus_4: pc_plus_4_in};

    // Handshake qualifiers.
    assign in_ready = (state_q != ST_FULL) && !do_branch;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // Next occupancy state and entry contents; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (do_branch) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end else if (!accept && consume) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end else if (accept && consume) begin
                        main_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only draining can happen.
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty register.
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Number of valid entries a flush squashes; a head entry that decode
    // takes in the flush cycle has been delivered, not squashed.
    always_comb begin
        flush_addend = 2'd0;
        if (do_branch) begin
            case (state_q)
                ST_ONE:  flush_addend = consume ? 2'd0 : 2'd1;
                ST_FULL: flush_addend = consume ? 2'd1 : 2'd2;
                default: flush_addend = 2'd0;
            endcase
        end
    end

    // Saturating accumulation of squashed instructions.
    always_comb begin
        flush_sum = {1'b0, flush_count_q} + {{(CNT_W-1){1'b0}}, flush_addend};
        if (flush_sum[CNT_W]) begin
            flush_count_d = '1;
        end else begin
            flush_count_d = flush_sum[CNT_W-1:0];
        end
    end

    // State, entry and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_EMPTY;
            out_valid_q   <= 1'b0;
            main_q        <= BUBBLE;
            skid_q        <= BUBBLE;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= (state_d != ST_EMPTY);
            main_q        <= main_d;
            skid_q        <= skid_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign pc_out          = main_q.pc;
    assign instruction_out = main_q.insn;
    assign pc_plus_4_out   = main_q.pc_plus_4;
    assign flush_count     = flush_count_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios followed by random traffic,
// all checked against a queue-based occupancy model. A second instance with
// a 2-bit counter shares the stimulus to exercise counter saturation.
module tb_if_id_skid_reg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready, in_ready_s;
    logic [XLEN-1:0] pc_in = '0;
    logic [31:0]     instruction_in = '0;
    logic [XLEN-1:0] pc_plus_4_in = '0;
    logic            do_branch = 1'b0;
    logic            out_valid, out_valid_s;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] pc_out, pc_out_s;
    logic [31:0]     instruction_out, instruction_out_s;
    logic [XLEN-1:0] pc_plus_4_out, pc_plus_4_out_s;
    logic [15:0]     flush_count;
    logic [1:0]      flush_count_s;
    logic [1:0]      state_dbg, state_dbg_s;

    if_id_skid_reg #(.XLEN(XLEN), .NOP_INSN(NOP), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in), .pc_plus_4_in(pc_plus_4_in),
        .do_branch(do_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instruction_out(instruction_out), .pc_plus_4_out(pc_plus_4_out),
        .flush_count(flush_count), .state_dbg(state_dbg)
    );

    if_id_skid_reg #(.XLEN(XLEN), .NOP_INSN(NOP), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .pc_in(pc_in), .instruction_in(instruction_in), .pc_plus_4_in(pc_plus_4_in),
        .do_branch(do_branch),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .pc_out(pc_out_s), .instruction_out(instruction_out_s), .pc_plus_4_out(pc_plus_4_out_s),
        .flush_count(flush_count_s), .state_dbg(state_dbg_s)
    );

    // ---------------- scoreboard ----------------
    // exp_q holds {pc, insn, pc_plus_4} of accepted-but-not-consumed
    // instructions in acceptance order; its head is what decode must see.
    logic [3*XLEN-1:0] exp_q[$];
    int unsigned       squashed_total = 0;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? 128'(max) : 128'(v);
    endfunction

    // Compare every registered output of both instances with the model.
    task automatic check_outputs();
        logic [3*XLEN-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : {{XLEN{1'b0}}, NOP, {XLEN{1'b0}}};
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        check_eq("pc_out", pc_out, head[3*XLEN-1:2*XLEN]);
        check_eq("instruction_out", instruction_out, head[2*XLEN-1:XLEN]);
        check_eq("pc_plus_4_out", pc_plus_4_out, head[XLEN-1:0]);
        check_eq("occupancy", state_dbg, exp_q.size());
        check_eq("flush_count", flush_count, sat(squashed_total, 65535));
        check_eq("flush_count_sat", flush_count_s, sat(squashed_total, 3));
        check_eq("small_pc_out", pc_out_s, head[3*XLEN-1:2*XLEN]);
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive one cycle of inputs, check the
    // combinational ready, advance the model as the next edge will, then
    // check the registered outputs after that edge.
    task automatic step(input bit v, input logic [XLEN-1:0] pc, input logic [31:0] insn,
                        input bit br, input bit ordy);
        bit acc, con;
        in_valid       = v;
        pc_in          = pc;
        instruction_in = insn;
        pc_plus_4_in   = pc + 4;
        do_branch      = br;
        out_ready      = ordy;
        #1;
        check_eq("in_ready", in_ready, (exp_q.size() < 2) && !br);
        acc = v && (exp_q.size() < 2) && !br;
        con = (exp_q.size() > 0) && ordy;
        if (br) begin
            squashed_total += exp_q.size() - (con ? 1 : 0);
            exp_q.delete();
        end else begin
            if (con) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({pc, insn, pc + 32'd4});
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic do_reset();
        in_valid  = 1'b0;
        do_branch = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        squashed_total = 0;
        #1;
        check_outputs();
        check_eq("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("reset_insn", instruction_out, 32'h13);
        check_eq("reset_count", flush_count, 0);

        // Flush from FULL without consume squashes two instructions.
        step(1'b1, 32'h40, 32'h1111_0001, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'h1111_0002, 1'b0, 1'b0);
        check_eq("fill_in_ready", in_ready, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("flush_full_valid", out_valid, 1'b0);
        check_eq("flush_full_insn", instruction_out, NOP);
        check_eq("flush_full_count", flush_count, 2);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0, 1'b1);
            check_eq("stream_pc", pc_out, 32'(i * 4));
            check_eq("stream_pc4", pc_plus_4_out, 32'(i * 4 + 4));
        end
        idle(2);

        // Skid: decode stalls in the cycle 0x104 is accepted.
        step(1'b1, 32'h100, 32'h3000_0000, 1'b0, 1'b1);
        step(1'b1, 32'h104, 32'h3000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h108, 32'h3000_0002, 1'b0, 1'b0);
        check_eq("skid_hold_pc", pc_out, 32'h100);
        step(1'b1, 32'h108, 32'h3000_0002, 1'b0, 1'b1);
        check_eq("skid_drain_pc", pc_out, 32'h104);
        step(1'b1, 32'h108, 32'h3000_0002, 1'b0, 1'b1);
        check_eq("skid_last_pc", pc_out, 32'h108);
        idle(2);

        // Flush from ONE with consume adds nothing; without consume adds one.
        step(1'b1, 32'h200, 32'h4000_0000, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check_eq("flush_consume_count", flush_count, 2);
        check_eq("flush_consume_state", state_dbg, 2'd0);
        step(1'b1, 32'h204, 32'h4000_0001, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("flush_one_count", flush_count, 3);
        // Held flush adds nothing after its first cycle.
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("held_flush_count", flush_count, 3);

        // Saturation of the 2-bit counter over three FULL flushes.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h300 + 32'(k * 8), 32'h5000_0000, 1'b0, 1'b0);
            step(1'b1, 32'h304 + 32'(k * 8), 32'h5000_0001, 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b1, 1'b0);
            check_eq("sat_count", flush_count_s, 2'd3);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 32'($urandom()) & ~32'h3,
                 32'($urandom()),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
            if (i == 1500) do_reset();
        end

        // Reset in the middle of a FULL register discards without counting.
        step(1'b1, 32'h500, 32'h6000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h6000_0001, 1'b0, 1'b0);
        do_reset();
        check_eq("midreset_count", flush_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
